ex_stage_module: RTL and testbench
==================================

Name: ex_stage_module

Overview:
Execute stage of the 5-stage ARM pipeline. It sits directly downstream of the decode stage and its ID/EX register. It consumes the registered decode outputs and produces:
- the shifter operand (Val2) and ALU result,
- the branch target and branch-taken signal back to fetch,
- the architectural status register (NZCV), fed back to decode,
- the EX/MEM pipeline register.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, register/ALU data width
REG_AW, 4, register-file address width
SR_W, 4, status register width, {N,Z,C,V}

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset
freeze  in  1  hold EX/MEM register and SR (memory stall)
wb_en_in  in  1  writeback enable from ID/EX
mem_r_en_in  in  1  load
mem_w_en_in  in  1  store
b_in  in  1  branch instruction
s_in  in  1  update status register
exec_cmd  in  4  ALU command
pc_in  in  ADDR_W  PC+4 of this instruction
val_r_n  in  DATA_W  Rn value
val_r_m  in  DATA_W  Rm value
imm  in  1  immediate operand
shift_operand  in  12  shifter field
signed_imm_24  in  24  branch offset
dest_in  in  REG_AW  destination register
sel_src_1  in  2  Rn forward select (00 reg, 01 MEM, 10 WB)
sel_src_2  in  2  Rm forward select
fwd_mem_val  in  DATA_W  EX/MEM alu_result
fwd_wb_val  in  DATA_W  writeback value
branch_taken  out  1  combinational, equals b_in
branch_address  out  ADDR_W  combinational target
status_reg_out  out  SR_W  registered NZCV
wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls
alu_result  out  DATA_W  registered result/address
store_val  out  DATA_W  registered forwarded Rm
dest_out  out  REG_AW  registered destination

Behaviour:
- Reset (rst=0, async): every registered output and the status register are 0.
- Forwarding select 11 behaves as 00.
- Operand A: Rn after its forwarding mux.
- Operand B: Rm after its forwarding mux.

Val2 generation:
- If imm=1: Val2 = ROR({24'b0, shift_operand[7:0]}, 2*shift_operand[11:8]).
- Else if mem_r_en_in or mem_w_en_in: Val2 = zero-extended shift_operand[11:0].
- Else: B shifted by shift_operand[11:7]. The shift type is shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes B unchanged.

ALU commands:
- 0001 MOV: Val2.
- 1001 MVN: ~Val2.
- 0010 ADD: A+Val2. Also used for LDR/STR address.
- 0011 ADC: A+Val2+C.
- 0100 SUB/CMP: A−Val2.
- 0101 SBC: A−Val2−!C.
- 0110 AND/TST: A&Val2.
- 0111 ORR: A|Val2.
- 1000 EOR: A^Val2.
- Any other code: result 0, flags unchanged.

Flags:
- N = result[31]; Z = (result==0).
- Arithmetic: C = carry-out of the 33-bit sum. For SUB/SBC, C = 1 when there is no borrow. V = signed overflow.
- Logic/MOV/MVN: C and V keep their current SR values.
- ADC/SBC take C from the current SR.

Status register:
- Loads the new NZCV on posedge when s_in=1 and freeze=0; otherwise it holds.
- A CMP followed immediately by a conditional instruction sees the updated SR one cycle later.

Branch:
- branch_address = pc_in + sign-extend({signed_imm_24, 2'b00}). Wraps modulo 2^ADDR_W.
- Combinational, same cycle as the ID/EX outputs.

EX/MEM register:
- 1-cycle latency.
- freeze=1 holds all fields, including when rst is not asserted.
- Reset asserted mid-stall still clears the register.
- No flush input: a branch in EX never squashes itself.

Optional Feature:
EXEC_FORWARDING_EN
- Defined: the sel_src_1 and sel_src_2 muxes operate as described.
- Undefined: the sel_src ports and fwd_* inputs are ignored. A=val_r_n and B=val_r_m directly. Hazards are then resolved by decode stalling only.

Test Plan:
1. Reset: rst=0 mid-operation → all outputs 0, status_reg_out=0000 immediately, without waiting for a clock edge.
2. ADD with s_in=1, A=0x7FFFFFFF, imm=1, shift_operand=0x001 → next cycle alu_result=0x80000000, status_reg_out=1001 (N,V).
3. CMP: A=5, Val2=5, s_in=1 → SR=0110 (Z,C). Follow with ADC A=1, Val2=1 → alu_result=3.
4. Shifter: val_r_m=0x80000001, shift_operand=0x0E0 (ROR #1) → MOV result 0xC0000000. shift_operand=0x0C0 (ASR #1) → 0xC0000000. imm ROR: shift_operand=0x2FF → 0xF000000F.
5. Branch: pc_in=0x100, signed_imm_24=0xFFFFFE, b_in=1 → branch_taken=1, branch_address=0x0F8 in the same cycle.
6. freeze=1 for 3 cycles with new inputs → EX/MEM outputs and SR unchanged. With EXEC_FORWARDING_EN, sel_src_1=01, fwd_mem_val=0x10, ADD Val2=1 → 0x11.

Source files
------------

// File: rtl/ex_stage_module.sv
// Execute stage: operand forwarding, shifter operand, ALU with NZCV, branch target and EX/MEM register.
// Optional macro EXEC_FORWARDING_EN enables the sel_src_1/sel_src_2 forwarding muxes.
module ex_stage_module #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int SR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exec_cmd,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_r_n,
  input  logic [DATA_W-1:0] val_r_m,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm_24,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [1:0]        sel_src_1,
  input  logic [1:0]        sel_src_2,
  input  logic [DATA_W-1:0] fwd_mem_val,
  input  logic [DATA_W-1:0] fwd_wb_val,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_address,
  output logic [SR_W-1:0]   status_reg_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_val,
  output logic [REG_AW-1:0] dest_out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] val2;
  logic [4:0]        shift_amt;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              flag_c;
  logic              flag_v;
  logic              cmd_known;
  logic [SR_W-1:0]   nzcv_next;
  logic [SR_W-1:0]   sr_q;

  function automatic logic [DATA_W-1:0] ror_data(input logic [DATA_W-1:0] v, input logic [4:0] amt);
    logic [2*DATA_W-1:0] d;
    d = {v, v} >> amt;
    return d[DATA_W-1:0];
  endfunction

`ifdef EXEC_FORWARDING_EN
  // Select 11 is treated like 00 so an undefined encoding never picks stale data.
  always_comb begin
    case (sel_src_1)
      2'b01:   op_a = fwd_mem_val;
      2'b10:   op_a = fwd_wb_val;
      default: op_a = val_r_n;
    endcase
    case (sel_src_2)
      2'b01:   op_b = fwd_mem_val;
      2'b10:   op_b = fwd_wb_val;
      default: op_b = val_r_m;
    endcase
  end
`else
  logic unused_fwd;
  assign op_a       = val_r_n;
  assign op_b       = val_r_m;
  assign unused_fwd = ^{sel_src_1, sel_src_2, fwd_mem_val, fwd_wb_val};
`endif

  always_comb begin
    shift_amt = shift_operand[11:7];
    val2      = op_b;
    if (imm) begin
      val2 = ror_data({{(DATA_W-8){1'b0}}, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_r_en_in || mem_w_en_in) begin
      val2 = {{(DATA_W-12){1'b0}}, shift_operand};
    end else if (shift_amt != 5'd0) begin
      case (shift_operand[6:5])
        2'b00:   val2 = op_b << shift_amt;
        2'b01:   val2 = op_b >> shift_amt;
        2'b10:   val2 = DATA_W'($signed(op_b) >>> shift_amt);
        default: val2 = ror_data(op_b, shift_amt);
      endcase
    end
  end

  // Subtraction is A + ~B + cin, so carry-out directly means "no borrow".
  always_comb begin
    add_b   = val2;
    add_cin = 1'b0;
    case (exec_cmd)
      CMD_ADC: add_cin = sr_q[1];
      CMD_SUB: begin
        add_b   = ~val2;
        add_cin = 1'b1;
      end
      CMD_SBC: begin
        add_b   = ~val2;
        add_cin = sr_q[1];
      end
      default: add_cin = 1'b0;
    endcase
    sum = {1'b0, op_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  end

  always_comb begin
    result    = '0;
    flag_c    = sr_q[1];
    flag_v    = sr_q[0];
    cmd_known = 1'b1;
    case (exec_cmd)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        result = sum[DATA_W-1:0];
        flag_c = sum[DATA_W];
        flag_v = (op_a[DATA_W-1] == add_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
      end
      CMD_AND: result = op_a & val2;
      CMD_ORR: result = op_a | val2;
      CMD_EOR: result = op_a ^ val2;
      default: cmd_known = 1'b0;
    endcase
    nzcv_next = sr_q;
    if (cmd_known) begin
      nzcv_next = {result[DATA_W-1], (result == '0), flag_c, flag_v};
    end
  end

  assign branch_taken   = b_in;
  assign branch_address = pc_in + {{(ADDR_W-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign status_reg_out = sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (s_in && !freeze) begin
      sr_q <= nzcv_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_result   <= '0;
      store_val    <= '0;
      dest_out     <= '0;
    end else if (!freeze) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      mem_w_en_out <= mem_w_en_in;
      alu_result   <= result;
      store_val    <= op_b;
      dest_out     <= dest_in;
    end
  end

endmodule

// File: tb/tb_ex_stage_module.sv
// Directed self-checking bench for ex_stage_module; the forwarding test adapts to EXEC_FORWARDING_EN.
module tb_ex_stage_module;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        b_in;
  logic        s_in;
  logic [3:0]  exec_cmd;
  logic [31:0] pc_in;
  logic [31:0] val_r_n;
  logic [31:0] val_r_m;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src_1;
  logic [1:0]  sel_src_2;
  logic [31:0] fwd_mem_val;
  logic [31:0] fwd_wb_val;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  status_reg_out;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic        mem_w_en_out;
  logic [31:0] alu_result;
  logic [31:0] store_val;
  logic [3:0]  dest_out;

  int checks = 0;
  int errors = 0;

  ex_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exec_cmd(exec_cmd), .pc_in(pc_in),
    .val_r_n(val_r_n), .val_r_m(val_r_m), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest_in(dest_in),
    .sel_src_1(sel_src_1), .sel_src_2(sel_src_2),
    .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .status_reg_out(status_reg_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_result(alu_result), .store_val(store_val), .dest_out(dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task clear_inputs;
    freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
    exec_cmd = 4'b0000; pc_in = 0; val_r_n = 0; val_r_m = 0; imm = 0;
    shift_operand = 0; signed_imm_24 = 0; dest_in = 0;
    sel_src_1 = 0; sel_src_2 = 0; fwd_mem_val = 0; fwd_wb_val = 0;
  endtask

  task set_alu(input logic [3:0] cmd, input logic s, input logic [31:0] a,
               input logic [31:0] rm, input logic im, input logic [11:0] shop);
    exec_cmd = cmd; s_in = s; val_r_n = a; val_r_m = rm; imm = im; shift_operand = shop;
  endtask

  task step;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    $display("[TB] test_reset");
    clear_inputs();
    rst = 1'b0;
    #3;
    checks++; if (alu_result !== 32'h0 || status_reg_out !== 4'h0 || dest_out !== 4'h0) begin
      errors++; $display("FAIL reset_initial got alu=%h sr=%b dest=%h expected 0", alu_result, status_reg_out, dest_out);
    end
    step();
    rst = 1'b1;
    wb_en_in = 1; mem_w_en_in = 1; dest_in = 4'hA;
    set_alu(4'b0001, 1'b1, 32'h0, 32'hAAAA5555, 1'b1, 12'h0FF);
    step();
    checks++; if (alu_result !== 32'hFF || wb_en_out !== 1'b1 || dest_out !== 4'hA) begin
      errors++; $display("FAIL reset_preload got alu=%h wb=%b dest=%h expected alu=000000ff wb=1 dest=a", alu_result, wb_en_out, dest_out);
    end
    rst = 1'b0;
    #1;
    checks++; if ({wb_en_out, mem_r_en_out, mem_w_en_out} !== 3'b000 || alu_result !== 32'h0 ||
                  store_val !== 32'h0 || dest_out !== 4'h0 || status_reg_out !== 4'h0) begin
      errors++; $display("FAIL reset_async got ctl=%b alu=%h st=%h dest=%h sr=%b expected all 0",
                         {wb_en_out, mem_r_en_out, mem_w_en_out}, alu_result, store_val, dest_out, status_reg_out);
    end
    clear_inputs();
    step();
    rst = 1'b1;
  endtask

  task test_add_overflow;
    $display("[TB] test_add_overflow");
    clear_inputs();
    set_alu(4'b0010, 1'b1, 32'h7FFFFFFF, 32'h0, 1'b1, 12'h001);
    step();
    checks++; if (alu_result !== 32'h80000000) begin
      errors++; $display("FAIL add_ovf_result got %h expected 80000000", alu_result);
    end
    checks++; if (status_reg_out !== 4'b1001) begin
      errors++; $display("FAIL add_ovf_sr got %b expected 1001", status_reg_out);
    end
  endtask

  task test_cmp_adc;
    $display("[TB] test_cmp_adc");
    clear_inputs();
    set_alu(4'b0100, 1'b1, 32'd5, 32'h0, 1'b1, 12'h005);
    step();
    checks++; if (status_reg_out !== 4'b0110 || alu_result !== 32'h0) begin
      errors++; $display("FAIL cmp_sr got sr=%b alu=%h expected sr=0110 alu=0", status_reg_out, alu_result);
    end
    set_alu(4'b0011, 1'b0, 32'd1, 32'h0, 1'b1, 12'h001);
    step();
    checks++; if (alu_result !== 32'd3 || status_reg_out !== 4'b0110) begin
      errors++; $display("FAIL adc_carry got alu=%h sr=%b expected alu=3 sr=0110", alu_result, status_reg_out);
    end
    set_alu(4'b0101, 1'b0, 32'd10, 32'h0, 1'b1, 12'h003);
    step();
    checks++; if (alu_result !== 32'd7) begin
      errors++; $display("FAIL sbc_c1 got %h expected 7", alu_result);
    end
    set_alu(4'b0010, 1'b1, 32'd1, 32'h0, 1'b1, 12'h001);
    step();
    checks++; if (status_reg_out !== 4'b0000) begin
      errors++; $display("FAIL add_clear_sr got %b expected 0000", status_reg_out);
    end
    set_alu(4'b0101, 1'b0, 32'd10, 32'h0, 1'b1, 12'h003);
    step();
    checks++; if (alu_result !== 32'd6) begin
      errors++; $display("FAIL sbc_c0 got %h expected 6", alu_result);
    end
    set_alu(4'b1001, 1'b1, 32'd0, 32'h0, 1'b1, 12'h000);
    step();
    checks++; if (alu_result !== 32'hFFFFFFFF || status_reg_out !== 4'b1000) begin
      errors++; $display("FAIL mvn got alu=%h sr=%b expected alu=ffffffff sr=1000", alu_result, status_reg_out);
    end
    set_alu(4'b0000, 1'b1, 32'd7, 32'h0, 1'b1, 12'h001);
    step();
    checks++; if (alu_result !== 32'h0 || status_reg_out !== 4'b1000) begin
      errors++; $display("FAIL bad_cmd got alu=%h sr=%b expected alu=0 sr=1000", alu_result, status_reg_out);
    end
    set_alu(4'b1000, 1'b0, 32'hF0F0F0F0, 32'h0, 1'b1, 12'h0FF);
    step();
    checks++; if (alu_result !== 32'hF0F0F00F) begin
      errors++; $display("FAIL eor got %h expected f0f0f00f", alu_result);
    end
  endtask

  task test_shifter;
    logic [11:0] shops [6];
    logic [31:0] exps  [6];
    $display("[TB] test_shifter");
    clear_inputs();
    shops[0] = 12'h0E0; exps[0] = 32'hC0000000;
    shops[1] = 12'h0C0; exps[1] = 32'hC0000000;
    shops[2] = 12'h200; exps[2] = 32'h00000010;
    shops[3] = 12'h220; exps[3] = 32'h08000000;
    shops[4] = 12'h060; exps[4] = 32'h80000001;
    shops[5] = 12'h0A0; exps[5] = 32'h40000000;
    for (int i = 0; i < 6; i++) begin
      set_alu(4'b0001, 1'b0, 32'h0, 32'h80000001, 1'b0, shops[i]);
      step();
      checks++; if (alu_result !== exps[i]) begin
        errors++; $display("FAIL shift_%0d got %h expected %h", i, alu_result, exps[i]);
      end
    end
    set_alu(4'b0001, 1'b0, 32'h0, 32'h80000001, 1'b1, 12'h2FF);
    step();
    checks++; if (alu_result !== 32'hF000000F) begin
      errors++; $display("FAIL imm_ror got %h expected f000000f", alu_result);
    end
    mem_r_en_in = 1;
    set_alu(4'b0010, 1'b0, 32'h1000, 32'h80000001, 1'b0, 12'hFFF);
    step();
    checks++; if (alu_result !== 32'h1FFF || mem_r_en_out !== 1'b1) begin
      errors++; $display("FAIL ldr_addr got alu=%h mr=%b expected alu=00001fff mr=1", alu_result, mem_r_en_out);
    end
    mem_r_en_in = 0; mem_w_en_in = 1;
    set_alu(4'b0010, 1'b0, 32'h100, 32'h0000DEAD, 1'b0, 12'h004);
    step();
    checks++; if (alu_result !== 32'h104 || store_val !== 32'h0000DEAD || mem_w_en_out !== 1'b1) begin
      errors++; $display("FAIL str got alu=%h st=%h mw=%b expected alu=104 st=dead mw=1", alu_result, store_val, mem_w_en_out);
    end
    mem_w_en_in = 0;
  endtask

  task test_branch;
    $display("[TB] test_branch");
    clear_inputs();
    pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE; b_in = 1;
    #1;
    checks++; if (branch_taken !== 1'b1 || branch_address !== 32'h0F8) begin
      errors++; $display("FAIL branch_back got taken=%b addr=%h expected taken=1 addr=000000f8", branch_taken, branch_address);
    end
    pc_in = 32'hFFFFFFFC; signed_imm_24 = 24'h000002;
    #1;
    checks++; if (branch_address !== 32'h4) begin
      errors++; $display("FAIL branch_wrap got %h expected 4", branch_address);
    end
    b_in = 0;
    #1;
    checks++; if (branch_taken !== 1'b0) begin
      errors++; $display("FAIL branch_not_taken got %b expected 0", branch_taken);
    end
  endtask

  task test_freeze;
    $display("[TB] test_freeze");
    clear_inputs();
    wb_en_in = 1; dest_in = 4'd5;
    set_alu(4'b0010, 1'b1, 32'd2, 32'h0, 1'b1, 12'h003);
    step();
    checks++; if (alu_result !== 32'd5 || status_reg_out !== 4'b0000 || dest_out !== 4'd5) begin
      errors++; $display("FAIL freeze_pre got alu=%h sr=%b dest=%h expected alu=5 sr=0000 dest=5", alu_result, status_reg_out, dest_out);
    end
    freeze = 1; wb_en_in = 0; dest_in = 4'd9;
    set_alu(4'b0001, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (alu_result !== 32'd5 || status_reg_out !== 4'b0000 || dest_out !== 4'd5 || wb_en_out !== 1'b1) begin
        errors++; $display("FAIL freeze_hold_%0d got alu=%h sr=%b dest=%h wb=%b expected alu=5 sr=0000 dest=5 wb=1",
                           i, alu_result, status_reg_out, dest_out, wb_en_out);
      end
    end
    rst = 1'b0;
    #1;
    checks++; if (alu_result !== 32'h0 || dest_out !== 4'h0 || wb_en_out !== 1'b0) begin
      errors++; $display("FAIL freeze_reset got alu=%h dest=%h wb=%b expected 0", alu_result, dest_out, wb_en_out);
    end
    step();
    rst = 1'b1; freeze = 0;
    step();
    checks++; if (status_reg_out !== 4'b0100 || dest_out !== 4'd9) begin
      errors++; $display("FAIL freeze_release got sr=%b dest=%h expected sr=0100 dest=9", status_reg_out, dest_out);
    end
  endtask

  task test_forwarding;
    $display("[TB] test_forwarding");
    clear_inputs();
    fwd_mem_val = 32'h10; fwd_wb_val = 32'h20;
    sel_src_1 = 2'b01;
    set_alu(4'b0010, 1'b0, 32'h99, 32'h0, 1'b1, 12'h001);
    step();
`ifdef EXEC_FORWARDING_EN
    checks++; if (alu_result !== 32'h11) begin
      errors++; $display("FAIL fwd_mem got %h expected 11", alu_result);
    end
    sel_src_1 = 2'b10;
    step();
    checks++; if (alu_result !== 32'h21) begin
      errors++; $display("FAIL fwd_wb got %h expected 21", alu_result);
    end
    sel_src_1 = 2'b11;
    step();
    checks++; if (alu_result !== 32'h9A) begin
      errors++; $display("FAIL fwd_sel11 got %h expected 9a", alu_result);
    end
    sel_src_1 = 2'b00; sel_src_2 = 2'b01;
    set_alu(4'b0001, 1'b0, 32'h0, 32'h55, 1'b0, 12'h000);
    step();
    checks++; if (alu_result !== 32'h10 || store_val !== 32'h10) begin
      errors++; $display("FAIL fwd_rm got alu=%h st=%h expected 10", alu_result, store_val);
    end
`else
    checks++; if (alu_result !== 32'h9A) begin
      errors++; $display("FAIL nofwd_rn got %h expected 9a", alu_result);
    end
    sel_src_2 = 2'b10;
    set_alu(4'b0001, 1'b0, 32'h0, 32'h55, 1'b0, 12'h000);
    step();
    checks++; if (alu_result !== 32'h55 || store_val !== 32'h55) begin
      errors++; $display("FAIL nofwd_rm got alu=%h st=%h expected 55", alu_result, store_val);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_cmp_adc();
    test_shifter();
    test_branch();
    test_freeze();
    test_forwarding();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
